// File: rtl/accum_skew_pkg.sv
// Shared types and defaults for the accumulator-output deskew sequencer.
package accum_skew_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } skew_ctrl_state_t;

endpackage

// File: rtl/accum_out_skew_ctrl_up_counter.sv
// Up counter with synchronous clear and increment enable; clear wins over increment.
module up_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/accum_out_skew_ctrl.sv
// Sequencer for the deskew FIFO bank: skew fill, valid/ready streaming of one tile,
// backpressure stall of the array and FIFO bank, and a completion pulse.
module accum_out_skew_ctrl
    import accum_skew_pkg::*;
#(
    parameter int ARRAY_HEIGHT = 4,
    parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_vec,
    output logic                   fifo_en,
    output logic                   fifo_enq,
    output logic                   array_stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] vec_idx,
    output logic                   busy,
    output logic                   done
);

    localparam int FILL_W    = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int FILL_LAST = (ARRAY_HEIGHT > 1) ? ARRAY_HEIGHT - 2 : 0;

    skew_ctrl_state_t       state_q, state_d;
    logic [COUNT_WIDTH-1:0] num_vec_q;
    logic [FILL_W-1:0]      fill_cnt;
    logic                   start_ok;
    logic                   xfer;
    logic                   at_last;

    assign start_ok = (state_q == IDLE) && start;
    assign xfer     = out_valid && out_ready;
    assign at_last  = (vec_idx == num_vec_q - COUNT_WIDTH'(1));

    up_counter #(.WIDTH(FILL_W)) u_fill_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (state_q == FILL),
        .count (fill_cnt)
    );

    up_counter #(.WIDTH(COUNT_WIDTH)) u_vec_idx (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .inc   (xfer),
        .count (vec_idx)
    );

    // busy and done are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            num_vec_q <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == FILL) || (state_d == STREAM);
            done    <= (state_d == DONE);
            if (start_ok) begin
                num_vec_q <= num_vec;
            end
        end
    end

    // NOTE: each combinational block assigns defaults first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_vec == '0) begin
                        state_d = DONE;
                    end else if (ARRAY_HEIGHT == 1) begin
                        state_d = STREAM;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_cnt == FILL_W'(FILL_LAST)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In STREAM the strobes follow out_ready directly so a stall freezes the bank the same cycle.
    always_comb begin
        fifo_en     = 1'b0;
        fifo_enq    = 1'b0;
        array_stall = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        case (state_q)
            FILL: begin
                fifo_en  = 1'b1;
                fifo_enq = 1'b1;
            end
            STREAM: begin
                out_valid   = 1'b1;
                out_last    = at_last;
                fifo_en     = out_ready;
                fifo_enq    = out_ready;
                array_stall = !out_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_accum_out_skew_ctrl.sv
// Scoreboard bench for accum_out_skew_ctrl: a tile-level timeline model predicts
// every cycle's strobes and each transfer; a negedge monitor compares.
module tb_accum_out_skew_ctrl;

    localparam int AH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          out_ready = 1'b1;
    logic          fifo_en, fifo_enq, array_stall, out_valid, out_last, busy, done;
    logic [CW-1:0] vec_idx;

    accum_out_skew_ctrl #(.ARRAY_HEIGHT(AH), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_vec     (num_vec),
        .fifo_en     (fifo_en),
        .fifo_enq    (fifo_enq),
        .array_stall (array_stall),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .vec_idx     (vec_idx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit enq;
        bit stall;
        bit valid;
        bit busy;
        bit last;
        int vidx;
    } cyc_exp_t;

    typedef struct {
        int cyc;
        int idx;
        bit last;
    } xfer_t;

    cyc_exp_t exp_at[int];
    bit       rdy_at[int];
    xfer_t    xfer_q[$];
    int       done_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against the model in the middle of each cycle.
    cyc_exp_t me;
    cyc_exp_t blank = '{default: 0};
    xfer_t    mx;
    int       md;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_fifo_en", fifo_en, 0);
            check("rst_fifo_enq", fifo_enq, 0);
            check("rst_array_stall", array_stall, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_last", out_last, 0);
            check("rst_vec_idx", vec_idx, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end else begin
            if (exp_at.exists(cyc)) me = exp_at[cyc];
            else me = blank;
            check("fifo_en", fifo_en, me.enq);
            check("fifo_enq", fifo_enq, me.enq);
            check("array_stall", array_stall, me.stall);
            check("out_valid", out_valid, me.valid);
            check("busy", busy, me.busy);
            if (me.valid) begin
                check("vec_idx", vec_idx, me.vidx);
                check("out_last", out_last, me.last);
            end
            if (out_valid && out_ready) begin
                if (xfer_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL xfer_unexpected at cycle %0d: got transfer idx %0d, expected none", cyc, vec_idx);
                end else begin
                    mx = xfer_q.pop_front();
                    check("xfer_cycle", cyc, mx.cyc);
                    check("xfer_idx", vec_idx, mx.idx);
                    check("xfer_last", out_last, mx.last);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL done_unexpected at cycle %0d: got done=1, expected 0", cyc);
                end else begin
                    md = done_q.pop_front();
                    check("done_cycle", cyc, md);
                end
            end else if (done_q.size() != 0 && done_q[0] < cyc) begin
                md = done_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL done_missing at cycle %0d: got no done, expected done at %0d", cyc, md);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ready_for(input int c);
        if (rdy_at.exists(c)) return rdy_at[c];
        return bit'($urandom_range(1));
    endfunction

    // Model: FILL spans t+1..t+AH-1; streaming starts at t+AH and advances one
    // vector per ready cycle; done follows the final transfer.
    task automatic plan_tile(input int t, input int n, input int pct,
                             input logic [63:0] stall_rel, output int done_c);
        cyc_exp_t e;
        int       c;
        int       k;
        bit       r;
        if (n == 0) begin
            done_c = t + 1;
        end else begin
            for (c = t + 1; c <= t + AH - 1; c++) begin
                e = blank;
                e.enq  = 1'b1;
                e.busy = 1'b1;
                exp_at[c] = e;
            end
            c = t + AH;
            k = 0;
            while (k < n) begin
                r = ($urandom_range(99) < pct);
                if (c - t < 64 && stall_rel[c - t]) r = 1'b0;
                rdy_at[c] = r;
                e = blank;
                e.busy  = 1'b1;
                e.valid = 1'b1;
                e.vidx  = k;
                e.last  = (k == n - 1);
                if (r) begin
                    e.enq = 1'b1;
                    xfer_q.push_back('{c, k, (k == n - 1)});
                    k++;
                end else begin
                    e.stall = 1'b1;
                end
                exp_at[c] = e;
                c++;
            end
            done_c = c;
        end
        done_q.push_back(done_c);
    endtask

    task automatic run_tile(input int n, input int pct, input logic [63:0] stall_rel,
                            input bit ign_mid, input bit ign_done);
        int t;
        int dc;
        t = cyc;
        plan_tile(t, n, pct, stall_rel, dc);
        start     = 1'b1;
        num_vec   = CW'(n);
        out_ready = ready_for(cyc);
        next_cycle();
        while (cyc <= dc) begin
            out_ready = ready_for(cyc);
            num_vec   = CW'($urandom);
            start     = 1'b0;
            if (ign_mid && cyc == t + 3) begin
                start   = 1'b1;
                num_vec = CW'(9);
            end else if (ign_done && cyc == dc) begin
                start   = 1'b1;
                num_vec = CW'($urandom_range(1, 20));
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic reset_mid_stream();
        int t;
        int dc;
        int ks[$];
        t = cyc;
        plan_tile(t, 4, 100, 64'h0, dc);
        start   = 1'b1;
        num_vec = CW'(4);
        next_cycle();
        start = 1'b0;
        while (cyc < t + 5) begin
            out_ready = 1'b1;
            next_cycle();
        end
        rst = 1'b1;
        foreach (exp_at[k]) if (k >= t + 5) ks.push_back(k);
        foreach (ks[i]) exp_at.delete(ks[i]);
        while (xfer_q.size() != 0 && xfer_q[$].cyc >= t + 5) void'(xfer_q.pop_back());
        done_q.delete();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        // Reset held from time zero with start asserted.
        rst     = 1'b1;
        start   = 1'b1;
        num_vec = CW'(5);
        repeat (3) next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) next_cycle();

        // Reset asserted mid-cycle, then start raised while reset is held.
        rst = 1'b1;
        #2;
        start   = 1'b1;
        num_vec = CW'(5);
        repeat (3) next_cycle();
        start = 1'b0;
        rst   = 1'b0;
        repeat (2) next_cycle();

        run_tile(4, 100, 64'h0, 1'b0, 1'b0);
        run_tile(4, 100, 64'h60, 1'b0, 1'b0);
        repeat (2) next_cycle();
        run_tile(0, 100, 64'h0, 1'b0, 1'b0);
        run_tile(1, 100, 64'h0, 1'b0, 1'b0);
        run_tile(4, 100, 64'h0, 1'b1, 1'b1);
        reset_mid_stream();
        run_tile(4, 100, 64'h0, 1'b0, 1'b0);

        repeat (40) begin
            run_tile($urandom_range(0, 12), $urandom_range(40, 100), 64'h0,
                     bit'($urandom_range(1)), bit'($urandom_range(1)));
            repeat ($urandom_range(0, 3)) next_cycle();
        end

        repeat (4) next_cycle();
        check("xfer_queue_empty", xfer_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/accum_out_skew_ctrl.md
# accum_out_skew_ctrl

Sequencer for the accumulator-output deskew FIFO bank that sits between the systolic array's bottom edge and the output buffer.
- On `start`, it runs one output tile of `num_vec` vectors.
- It drives the bank's enable and enqueue strobes through the skew fill.
- It presents aligned vectors to the output buffer over a valid/ready handshake.
- It stalls the array and the FIFO bank under downstream backpressure, then signals completion.

## Interface
Parameters:
- `ARRAY_HEIGHT`, 4: number of FIFO lanes; skew depth is `ARRAY_HEIGHT-1`.
- `COUNT_WIDTH`, 16: width of the vector count and index.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  one-cycle tile start; sampled only in IDLE.
- `num_vec`  in  COUNT_WIDTH  vectors in the tile; latched when `start` is accepted.
- `fifo_en`  out  1  enable to the deskew FIFO bank.
- `fifo_enq`  out  1  enqueue strobe to the deskew FIFO bank.
- `array_stall`  out  1  freezes the systolic array.
- `out_valid`  out  1  aligned output vector present on the FIFO outputs.
- `out_ready`  in  1  output buffer accepts the vector.
- `out_last`  out  1  marks the final vector of the tile; qualified by `out_valid`.
- `vec_idx`  out  COUNT_WIDTH  index of the current output vector, counting from 0.
- `busy`  out  1  tile in progress.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
States: IDLE, FILL, STREAM, DONE.
- **IDLE**
  - `start` with `num_vec`≠0: latch `num_vec`, clear counters, go to FILL. If `ARRAY_HEIGHT==1`, go directly to STREAM.
  - `start` with `num_vec`==0: go to DONE with no enqueue.
- **FILL**
  - `fifo_en=1`, `fifo_enq=1`, `out_valid=0`.
  - `fill_cnt` increments each cycle; after `ARRAY_HEIGHT-1` cycles, go to STREAM.
- **STREAM**
  - `fifo_enq=1`, `out_valid=1`.
  - Transfer = `out_valid && out_ready`. Each transfer increments `vec_idx`.
  - `out_last = (vec_idx == num_vec_q-1)`.
  - A transfer with `out_last` goes to DONE.
- **Stall**
  - Condition: `out_valid && !out_ready`.
  - Effect: `fifo_en=0`, `fifo_enq=0`, `array_stall=1`; `vec_idx` and all state hold.
  - `fifo_en`, `fifo_enq` and `array_stall` depend combinationally on `out_ready`.
- **DONE**
  - `done=1` for one cycle, then IDLE.
- **Total work per tile**
  - Exactly `num_vec + ARRAY_HEIGHT - 1` enqueue cycles.
  - Exactly `num_vec` output transfers.
- **Other rules**
  - `busy=1` in FILL and STREAM.
  - `start` outside IDLE is ignored, including a `start` in the DONE cycle.
  - `rst` asserted in any state forces IDLE and clears the counters and `num_vec_q`. The FIFO bank contents are not the controller's responsibility.
- **Widths**
  - `vec_idx` and `num_vec_q` are `COUNT_WIDTH` bits.
  - `fill_cnt` is `$clog2(ARRAY_HEIGHT)` bits, minimum 1.
  - No wrap: `num_vec` ≤ 2^COUNT_WIDTH-1.

## Timing
- **Reset values**
  - 0: `fifo_en`, `fifo_enq`, `array_stall`, `out_valid`, `out_last`, `vec_idx`, `busy`, `done`.
  - State: IDLE.
- **Tile timeline**, with `start` sampled at edge t:
  - FILL cycles: t+1 … t+`ARRAY_HEIGHT-1`.
  - First `out_valid`: cycle t+`ARRAY_HEIGHT`.
  - With `out_ready` held at 1, the last transfer is at t+`ARRAY_HEIGHT`+`num_vec`-1.
  - `done` is the following cycle; `busy` is low in that cycle.
- **Backpressure**: each cycle with `out_ready=0` during STREAM delays everything after it by one cycle.
- **Restart**: earliest accepted next `start` is the cycle after `done`, so the tile-to-tile gap is 2 cycles.
- **Registered outputs**: state, counters, `busy` and `done`.

## Structure
- **Package `accum_skew_pkg`**:
  - State enum typedef `skew_ctrl_state_t` (IDLE, FILL, STREAM, DONE).
  - Default `COUNT_WIDTH` constant.
- **Sub-module `up_counter`**: parameterized width, with `clr` and `inc` inputs. Instantiated twice, for `fill_cnt` and `vec_idx`.
- Top level holds the FSM and the combinational stall/strobe decode.

## Test plan
Configuration: `ARRAY_HEIGHT=4`, `COUNT_WIDTH=16`.
1. **Reset**: assert `rst` mid-cycle with `start=1` held → all outputs 0 and no state advance until `rst` is released.
2. **Nominal tile**: `start`, `num_vec=4`, `out_ready=1`
   - `fifo_enq` high for exactly 7 cycles, t+1..t+7.
   - `out_valid` high at t+4..t+7 with `vec_idx` 0,1,2,3; `out_last` at t+7.
   - `done` at t+8; `busy` low at t+8.
3. **Backpressure**: `num_vec=4`, `out_ready=0` at t+5 and t+6
   - `fifo_en`/`fifo_enq` low and `array_stall` high at t+5 and t+6.
   - `vec_idx` holds at 1; last transfer at t+9; `done` at t+10.
4. **Empty tile**: `num_vec=0` → `done` at t+1, no `fifo_enq` and no `out_valid` ever; `num_vec=1` → 4 enqueue cycles, single transfer at t+4 with `out_last=1`.
5. **Ignored start**: `start` with `num_vec=9` pulsed at t+3 while busy with `num_vec=4` → ignored; tile completes with 4 transfers.
6. **Reset mid-STREAM**: `rst` pulse at t+5 → IDLE, outputs 0 immediately; a new `start` after release runs a full 7-cycle enqueue sequence.
